// File: rtl/aq_dtu_halt_ctrl_pkg.sv
// aq_dtu_halt_ctrl_pkg: shared DTU halt states, dcsr cause codes and source indices
package aq_dtu_halt_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_RUN,
    ST_STEP,
    ST_HREQ,
    ST_HWAIT,
    ST_DEBUG,
    ST_RESUME
  } halt_st_e;
  localparam int CAUSE_EBREAK    = 1;
  localparam int CAUSE_TRIG      = 2;
  localparam int CAUSE_HALTREQ   = 3;
  localparam int CAUSE_STEP      = 4;
  localparam int CAUSE_RESETHALT = 5;
  localparam int SRC_EBREAK    = 0;
  localparam int SRC_TRIG      = 1;
  localparam int SRC_HALTREQ   = 2;
  localparam int SRC_STEP      = 3;
  localparam int SRC_RESETHALT = 4;
  localparam int SRC_N         = 5;
endpackage

// File: rtl/aq_dtu_halt_cause_pri.sv
// aq_dtu_halt_cause_pri: fixed-priority encoder of halt sources to a dcsr cause
module aq_dtu_halt_cause_pri
  import aq_dtu_halt_ctrl_pkg::*;
#(
  parameter int CAUSE_W = 3
) (
  input  logic [SRC_N-1:0]   src,
  output logic               vld,
  output logic [CAUSE_W-1:0] cause
);
  always_comb begin
    vld   = |src;
    cause = src[SRC_RESETHALT] ? CAUSE_W'(CAUSE_RESETHALT) :
            src[SRC_TRIG]      ? CAUSE_W'(CAUSE_TRIG)      :
            src[SRC_EBREAK]    ? CAUSE_W'(CAUSE_EBREAK)    :
            src[SRC_HALTREQ]   ? CAUSE_W'(CAUSE_HALTREQ)   :
            src[SRC_STEP]      ? CAUSE_W'(CAUSE_STEP)      : '0;
  end
endmodule

// File: rtl/aq_dtu_halt_ctrl.sv
// aq_dtu_halt_ctrl: debug-halt sequencer arbitrating halt sources and running the
// halt/ack, debug-mode and resume handshakes between trigger module, RTU and HAD.
module aq_dtu_halt_ctrl
  import aq_dtu_halt_ctrl_pkg::*;
#(
  parameter int CAUSE_W = 3
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst_b,
  input  logic               had_dtu_haltreq,
  input  logic               had_dtu_resethaltreq,
  input  logic               had_dtu_resumereq,
  input  logic               trig_dtu_halt_hit,
  input  logic               trig_dtu_pending_halt,
  input  logic               rtu_dtu_retire_vld,
  input  logic               rtu_dtu_retire_ebreak,
  input  logic               rtu_dtu_expt_vld,
  input  logic               rtu_dtu_halt_ack,
  input  logic               rtu_dtu_pending_ack,
  input  logic               rtu_yy_xx_dbgon,
  input  logic               dcsr_step,
  output logic               dtu_rtu_halt_req,
  output logic               dtu_rtu_pending_req,
  output logic               dtu_rtu_resume_req,
  output logic [CAUSE_W-1:0] dtu_cause,
  output logic               dtu_had_halted,
  output logic               dtu_had_resume_ack
);
  halt_st_e           state, state_nxt;
  logic               pend, first, rst_halt, hit, run_like;
  logic [SRC_N-1:0]   src;
  logic [CAUSE_W-1:0] cause_nxt;
  assign run_like = (state == ST_RUN) || (state == ST_STEP);
  // haltreq is masked in STEP so the step completes before an external halt is taken
  always_comb begin
    src                = '0;
    src[SRC_EBREAK]    = rtu_dtu_retire_ebreak;
    src[SRC_TRIG]      = trig_dtu_halt_hit | (pend & rtu_dtu_pending_ack);
    src[SRC_HALTREQ]   = had_dtu_haltreq & (state != ST_STEP);
    src[SRC_STEP]      = (state == ST_STEP) & (rtu_dtu_retire_vld | rtu_dtu_expt_vld);
    src[SRC_RESETHALT] = rst_halt;
  end
  aq_dtu_halt_cause_pri #(.CAUSE_W(CAUSE_W)) u_pri (
    .src   (src),
    .vld   (hit),
    .cause (cause_nxt)
  );
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) state <= ST_RUN;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN, ST_STEP: state_nxt = hit ? ST_HREQ : state;
      ST_HREQ:         state_nxt = rtu_dtu_halt_ack ? ST_HWAIT : ST_HREQ;
      ST_HWAIT:        state_nxt = rtu_yy_xx_dbgon ? ST_DEBUG : ST_HWAIT;
      ST_DEBUG:        state_nxt = had_dtu_resumereq ? ST_RESUME : ST_DEBUG;
      ST_RESUME:       state_nxt = rtu_yy_xx_dbgon ? ST_RESUME : (dcsr_step ? ST_STEP : ST_RUN);
      default:         state_nxt = ST_RUN;
    endcase
  end
  // pend only survives while running; resethalt is held until it wins a halt
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      pend               <= 1'b0;
      first              <= 1'b1;
      rst_halt           <= 1'b0;
      dtu_cause          <= '0;
      dtu_had_resume_ack <= 1'b0;
    end else begin
      first              <= 1'b0;
      rst_halt           <= first ? had_dtu_resethaltreq : rst_halt & ~(run_like & hit);
      pend               <= run_like & ~hit & (trig_dtu_pending_halt | (pend & ~rtu_dtu_pending_ack));
      dtu_cause          <= (run_like & hit) ? cause_nxt : dtu_cause;
      dtu_had_resume_ack <= (state == ST_RESUME) & ~rtu_yy_xx_dbgon;
    end
  end
  assign dtu_rtu_halt_req    = state == ST_HREQ;
  assign dtu_rtu_pending_req = pend;
  assign dtu_rtu_resume_req  = state == ST_RESUME;
  assign dtu_had_halted      = state == ST_DEBUG;
endmodule

// File: doc/aq_dtu_halt_ctrl.md
# aq_dtu_halt_ctrl

Debug-halt sequencer for the DTU. It collects every halt source: trigger hits from the trigger module, pending (timing-after) triggers, ebreak, debug-module haltreq/resethaltreq and single-step. It arbitrates them into one halt request toward the RTU and records the dcsr cause. It then runs the halt/ack, debug-mode and resume handshakes, and sits between the trigger module, the RTU and the HAD debug interface.

## Interface
Parameters:
- CAUSE_W, 3, width of dcsr.cause field

Ports:
- forever_cpuclk  in  1  core clock (only clock)
- cpurst_b  in  1  asynchronous active-low reset
- had_dtu_haltreq  in  1  level halt request from debug module
- had_dtu_resethaltreq  in  1  halt-on-reset request, sampled at first cycle after reset release
- had_dtu_resumereq  in  1  level resume request, honoured only in DEBUG
- trig_dtu_halt_hit  in  1  trigger (action=debug, timing=before) hit on retiring instr
- trig_dtu_pending_halt  in  1  trigger (timing=after) hit; halt owed after instr completes
- rtu_dtu_retire_vld  in  1  one instruction retired
- rtu_dtu_retire_ebreak  in  1  ebreak retired with matching dcsr.ebreak{m,s,u} set
- rtu_dtu_expt_vld  in  1  trap entry taken (counts as step completion)
- rtu_dtu_halt_ack  in  1  RTU accepted halt request
- rtu_dtu_pending_ack  in  1  RTU finished instr owing a pending halt
- rtu_yy_xx_dbgon  in  1  core is in debug mode
- dcsr_step  in  1  dcsr.step
- dtu_rtu_halt_req  out  1  halt request, level until ack
- dtu_rtu_pending_req  out  1  pending-halt armed, level until pending ack
- dtu_rtu_resume_req  out  1  resume request, level until dbgon falls
- dtu_cause  out  CAUSE_W  dcsr.cause of current/last halt
- dtu_had_halted  out  1  core halted (DEBUG state)
- dtu_had_resume_ack  out  1  one-cycle pulse on completed resume

## Operation
- States: RUN, STEP, HREQ, HWAIT, DEBUG, RESUME. Reset state RUN.
- Causes: 1 ebreak, 2 trigger, 3 haltreq, 4 step, 5 resethaltreq. Fixed priority when simultaneous: 5 > 2 > 1 > 3 > 4.
- RUN/STEP: any source present -> latch winning cause into dtu_cause, go HREQ.
- Pending trigger:
  - trig_dtu_pending_halt in RUN/STEP sets pend flag and dtu_rtu_pending_req.
  - rtu_dtu_pending_ack clears pend and raises source "trigger".
  - A pend flag set while in HREQ..DEBUG is dropped.
- STEP: entered from RESUME when dcsr_step=1. First rtu_dtu_retire_vld or rtu_dtu_expt_vld raises "step". haltreq is ignored in STEP until that event; higher causes still win.
- HREQ: dtu_rtu_halt_req=1. rtu_dtu_halt_ack -> HWAIT. Cause is frozen from HREQ entry until next halt.
- HWAIT: wait for rtu_yy_xx_dbgon=1 -> DEBUG.
- DEBUG: dtu_had_halted=1. All halt sources ignored. had_dtu_resumereq -> RESUME.
- RESUME: dtu_rtu_resume_req=1 until rtu_yy_xx_dbgon=0. On that cycle the next state is STEP if dcsr_step else RUN, with dtu_had_resume_ack pulsed for one cycle.
- resethaltreq: a one-shot flag captured on the first clock after reset deassertion. It forces HREQ with cause 5. Otherwise it is ignored.

## Timing
- Reset values: all outputs 0, dtu_cause=0, pend=0.
- Source -> dtu_rtu_halt_req: 1 cycle (registered).
- halt_ack -> halt_req low on the next edge. The ack is consumed only in HREQ and ignored elsewhere.
- Sources asserted in the same cycle as halt_ack do not re-trigger and are not queued. Exception: haltreq is a level input and is re-evaluated in RUN after resume.
- resumereq and dbgon fall in the same cycle while in RESUME: resume_ack still pulses once.
- A pending_ack arriving in the same cycle as a trigger_hit yields one halt, cause 2.
- Async reset mid-operation returns to RUN at once and clears the pend and resethaltreq flags. Outputs go to 0 with no handshake completion.

## Structure
- State encodings and cause constants (CAUSE_EBREAK=1, CAUSE_TRIG=2, CAUSE_HALTREQ=3, CAUSE_STEP=4, CAUSE_RESETHALT=5) go in the shared DTU define header.
- One sub-module, aq_dtu_halt_cause_pri: a combinational priority encoder from 5 source bits to a valid flag plus cause.
- FSM, pend flag and reset one-shot live in the top module.

## Test plan
- Bus-level sequence:
  - Stimulus: haltreq=1 in RUN -> ack after 3 cycles -> dbgon=1 -> resumereq -> dbgon=0.
  - Required: halt_req high for cycles 1-3 (1 cycle after haltreq, cleared 1 cycle after ack); cause=3; halted=1; resume_req until dbgon=0; then one resume_ack pulse; state RUN.
- trigger_hit and ebreak in the same cycle -> cause=2, single halt_req.
- Pending trigger:
  - Stimulus: trig_dtu_pending_halt=1; pending_ack 5 cycles later.
  - Required: pending_req high for those 5 cycles; halt_req 1 cycle after the ack; cause=2.
- Single step:
  - Stimulus: dcsr_step=1 through resume; haltreq held; retire_vld 4 cycles later.
  - Required: no halt before retire; halt_req 1 cycle after retire; cause=4 is overridden to 3? No: haltreq is masked in STEP, so cause=4.
- Reset halt: resethaltreq=1 at reset release -> halt_req in cycle 2, cause=5. Second reset with resethaltreq=0 -> stays RUN.
- Reset mid-HWAIT: assert cpurst_b=0 -> all outputs 0 in the same cycle; RUN after release.
